// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux codes
// and the main control FSM state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // opAlu codes, also decoded by alu_control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_BRANCH,
        S_JUMP,
        S_ADDIEX,
        S_ADDIWB
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [1:0] opAlu,
    output logic       illegal
);

    state_t state, next_state;
    logic   illegal_q;
    logic   set_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        set_illegal = 1'b0;
        case (state)
            S_FETCH:  next_state = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default: begin
                        next_state  = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            // only lw/sw can reach here, so anything but lw is a store
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_RWB;
            S_RWB:    next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        pcSource    = PCSRC_ALU;
        opAlu       = ALU_ADD;
        illegal     = 1'b0;
        // reset wins combinationally so a pending access is dropped in the same cycle
        if (!rst) begin
            illegal = illegal_q;
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_4;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_DECODE: aluSrcB = SRCB_IMMSH;
                S_MEMADR, S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                S_MEMWB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    opAlu   = ALU_FUNCT;
                end
                S_RWB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    opAlu       = ALU_SUB;
                    pcWriteCond = 1'b1;
                    pcSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = PCSRC_JUMP;
                end
                S_ADDIWB: regWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a per-instruction model
// queues the expected output word for every cycle, a monitor compares them.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegal;
    logic [1:0] aluSrcB, pcSource, opAlu;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .opAlu(opAlu), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle_no = 0;
    bit          ill_m = 1'b0;

    // field order: pcW pcWC iorD mRd mWr irW m2r rDst rW srcA srcB pcSrc alu
    function automatic logic [15:0] mk(bit pw, bit pwc, bit io, bit mrd, bit mwr,
                                       bit irw, bit m2r, bit rd, bit rw, bit sa,
                                       logic [1:0] sb, logic [1:0] ps, logic [1:0] alu);
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ps, alu};
    endfunction

    logic [15:0] V_FETCH, V_FETCH_RDY, V_DECODE, V_ADDR, V_MEMRD, V_MEMWB, V_MEMWR;
    logic [15:0] V_EXEC, V_RWB, V_BRANCH, V_JUMP, V_ADDIWB;

    initial begin
        V_FETCH     = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
        V_FETCH_RDY = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
        V_DECODE    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
        V_ADDR      = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
        V_MEMRD     = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
        V_MEMWB     = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
        V_MEMWR     = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
        V_EXEC      = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10);
        V_RWB       = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
        V_BRANCH    = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
        V_JUMP      = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00);
        V_ADDIWB    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
    end

    // one clock cycle: drive inputs, queue what the outputs must be this cycle
    task automatic cyc(input logic [15:0] v, input logic [5:0] op,
                       input logic mr, input logic r);
        rst      = r;
        opcode   = op;
        memReady = mr;
        expq.push_back(r ? 17'd0 : {v, ill_m});
        @(posedge clk);
        #1;
        if (r) ill_m = 1'b0;
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        repeat (wf) cyc(V_FETCH, rop(), 1'b0, 1'b0);
        cyc(V_FETCH_RDY, rop(), 1'b1, 1'b0);
        cyc(V_DECODE, op, rbit(), 1'b0);
        case (op)
            6'b100011, 6'b101011: begin
                cyc(V_ADDR, op, rbit(), 1'b0);
                if (op == 6'b100011) begin
                    repeat (wm) cyc(V_MEMRD, rop(), 1'b0, 1'b0);
                    cyc(V_MEMRD, rop(), 1'b1, 1'b0);
                    cyc(V_MEMWB, rop(), rbit(), 1'b0);
                end else begin
                    repeat (wm) cyc(V_MEMWR, rop(), 1'b0, 1'b0);
                    cyc(V_MEMWR, rop(), 1'b1, 1'b0);
                end
            end
            6'b000000: begin
                cyc(V_EXEC, rop(), rbit(), 1'b0);
                cyc(V_RWB, rop(), rbit(), 1'b0);
            end
            6'b000100: cyc(V_BRANCH, rop(), rbit(), 1'b0);
            6'b000010: cyc(V_JUMP, rop(), rbit(), 1'b0);
            6'b001000: begin
                cyc(V_ADDR, rop(), rbit(), 1'b0);
                cyc(V_ADDIWB, rop(), rbit(), 1'b0);
            end
            default: ill_m = 1'b1;
        endcase
    endtask

    // monitor: every cycle with a queued expectation gets compared mid-cycle
    always @(negedge clk) begin
        logic [16:0] got, exp;
        cycle_no++;
        if (expq.size() > 0) begin
            exp = expq.pop_front();
            got = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                   regDst, regWrite, aluSrcA, aluSrcB, pcSource, opAlu, illegal};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL outputs cycle %0d: got %b required %b", cycle_no, got, exp);
            end
        end
    end

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        rst = 1'b1; opcode = '0; memReady = 1'b0;
        @(posedge clk); #1;
        repeat (3) cyc(16'd0, rop(), rbit(), 1'b1);

        // directed: R, lw with 2 waits, beq, j
        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 0, 2);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        // illegal opcode, then addi with illegal still set, then reset clears it
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 1, 0);
        cyc(16'd0, rop(), rbit(), 1'b1);
        run_instr(6'b000000, 0, 0);

        // reset during a store wait: access abandoned, fetch resumes
        cyc(V_FETCH_RDY, rop(), 1'b1, 1'b0);
        cyc(V_DECODE, 6'b101011, 1'b0, 1'b0);
        cyc(V_ADDR, 6'b101011, 1'b0, 1'b0);
        cyc(V_MEMWR, rop(), 1'b0, 1'b0);
        cyc(16'd0, rop(), 1'b0, 1'b1);
        run_instr(6'b101011, 2, 1);

        // randomized instruction stream with random wait states
        for (int i = 0; i < 200; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? rop() : legal_ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0)
                cyc(16'd0, rop(), rbit(), 1'b1);
        end

        @(negedge clk); #1;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
